// File: rtl/pipelined_adder.sv
// Segmented carry-chain adder/subtractor, one W-bit segment per stage, with valid/ready flow control.
// Optional signed-overflow output is compiled in with PIPELINED_ADDER_OVF_EN.
module pipelined_adder #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int W = N / STAGES;

    // Subtraction is a + ~b + ~cin, so cout reads as "no borrow".
    logic [N-1:0] b_eff;
    logic         cin_eff;

    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? ~cin : cin;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;

    // A stage advances when out_ready is high or any stage after it is empty,
    // which is how bubbles collapse under backpressure.
    always_comb begin : p_flow
        logic room;
        // NOTE: every output gets a default first so no path leaves a latch;
        // 'room' is a running value, so it is updated with blocking assignments.
        adv      = '0;
        load     = '0;
        room     = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = v_q[k] && room;
            room   = room || !v_q[k];
        end
        in_ready = room;
        load[0]  = in_valid && room;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= '0;
        end else begin
            v_q <= load | (v_q & ~adv);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * W;

        // Operand bits still pending are kept right-aligned, so this stage always
        // consumes the low W bits of a_in/b_in.
        logic [N-LO-1:0]  a_in;
        logic [N-LO-1:0]  b_in;
        logic             c_in;
        logic [W:0]       part;
        logic [LO+W-1:0]  s_d;
        logic [LO+W-1:0]  s_q;
        logic             c_q;

        assign part = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};

        if (k == 0) begin : g_in
            assign a_in = a;
            assign b_in = b_eff;
            assign c_in = cin_eff;
            assign s_d  = part[W-1:0];
        end else begin : g_in
            assign a_in = g_stg[k-1].g_fwd.a_q;
            assign b_in = g_stg[k-1].g_fwd.b_q;
            assign c_in = g_stg[k-1].c_q;
            assign s_d  = {part[W-1:0], g_stg[k-1].s_q};
        end

        // NOTE: data registers are reset too, so outputs read 0 after reset
        // until the first result arrives.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (load[k]) begin
                s_q <= s_d;
                c_q <= part[W];
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [N-LO-W-1:0] a_q;
            logic [N-LO-W-1:0] b_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load[k]) begin
                    a_q <= a_in[N-LO-1:W];
                    b_q <= b_in[N-LO-1:W];
                end
            end
        end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    // The top segment sees the sign bits of a, b_eff and the sum together.
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = (g_stg[STAGES-1].a_in[W-1] == g_stg[STAGES-1].b_in[W-1]) &&
                   (g_stg[STAGES-1].part[W-1] != g_stg[STAGES-1].a_in[W-1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (load[STAGES-1]) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign out_valid = v_q[STAGES-1];
    assign sum       = g_stg[STAGES-1].s_q;
    assign cout      = g_stg[STAGES-1].c_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (N=16, STAGES=4) with a result scoreboard.
// Overflow checks are compiled in with PIPELINED_ADDER_OVF_EN.
module tb_pipelined_adder;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
    } op_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic        ovf;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    res_t sb[$];

    pipelined_adder #(.N(16), .STAGES(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width N+1-bit arithmetic.
    function automatic res_t model(input op_t op);
        res_t        r;
        logic [15:0] be;
        logic        ce;
        logic [16:0] t;
        be     = op.sub ? ~op.b : op.b;
        ce     = op.sub ? ~op.cin : op.cin;
        t      = {1'b0, op.a} + {1'b0, be} + {16'd0, ce};
        r.sum  = t[15:0];
        r.cout = t[16];
`ifdef PIPELINED_ADDER_OVF_EN
        r.ovf  = (op.a[15] == be[15]) && (t[15] != op.a[15]);
`else
        r.ovf  = 1'b0;
`endif
        return r;
    endfunction

    function automatic res_t observe();
        res_t r;
        r.sum  = sum;
        r.cout = cout;
`ifdef PIPELINED_ADDER_OVF_EN
        r.ovf  = ovf;
`else
        r.ovf  = 1'b0;
`endif
        return r;
    endfunction

    function automatic op_t rand_op();
        op_t op;
        op.a   = 16'($urandom);
        op.b   = 16'($urandom);
        if ($urandom_range(0, 7) == 0) op.a = 16'hFFFF;
        if ($urandom_range(0, 7) == 0) op.b = 16'h8000;
        op.cin = 1'($urandom);
        op.sub = 1'($urandom);
        return op;
    endfunction

    // One clock: sample handshakes at the falling edge, push accepted ops to the scoreboard.
    task automatic cycle(output logic acc, output logic deq, output res_t obs);
        @(negedge clk);
        acc = in_valid && in_ready;
        deq = out_valid && out_ready;
        obs = observe();
        if (acc) sb.push_back(model({a, b, cin, sub}));
        @(posedge clk);
        #1;
    endtask

    task automatic run_ops(input op_t ops [4], input int n, output res_t got [4], output int n_got);
        logic acc, deq;
        res_t obs;
        int   sent;
        sent      = 0;
        n_got     = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && n_got < n; c++) begin
            in_valid = (sent < n);
            if (sent < n) {a, b, cin, sub} = ops[sent];
            cycle(acc, deq, obs);
            if (acc) sent++;
            if (deq) begin
                if (sb.size() > 0) void'(sb.pop_front());
                got[n_got] = obs;
                n_got++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({out_valid, observe()} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got out_valid=%b res=%h, expected all zero", out_valid, observe());
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
    endtask

    // Offered in cycle 0, the result must show on the fourth falling edge after acceptance.
    task automatic test_boundary_add();
        logic acc, deq;
        res_t obs;
        int   lat;
        out_ready = 1'b1;
        {a, b, cin, sub} = {16'hFFFF, 16'h0001, 1'b0, 1'b0};
        in_valid = 1'b1;
        cycle(acc, deq, obs);
        in_valid = 1'b0;
        n_cmp++;
        if (acc !== 1'b1) begin
            n_err++;
            $display("FAIL boundary_accept: got %b expected 1", acc);
        end
        lat = -1;
        for (int j = 1; j <= 20 && lat < 0; j++) begin
            cycle(acc, deq, obs);
            if (deq) begin
                lat = j;
                if (sb.size() > 0) void'(sb.pop_front());
                n_cmp++;
                if (obs.sum !== 16'h0000 || obs.cout !== 1'b1) begin
                    n_err++;
                    $display("FAIL boundary_add: got sum=%h cout=%b expected 0000 1", obs.sum, obs.cout);
                end
            end
        end
        n_cmp++;
        if (lat != 4) begin
            n_err++;
            $display("FAIL boundary_latency: got %0d expected 4", lat);
        end
    endtask

    task automatic test_add_sub();
        op_t         ops [4];
        res_t        got [4];
        int          ng;
        logic [15:0] exp_sum [4];
        logic        exp_cout [4];
        ops[0] = {16'h0005, 16'h0007, 1'b0, 1'b1};
        ops[1] = {16'h0007, 16'h0005, 1'b1, 1'b1};
        ops[2] = {16'h1234, 16'h0FFF, 1'b1, 1'b0};
        ops[3] = {16'h8000, 16'h8000, 1'b1, 1'b0};
        exp_sum  = '{16'hFFFE, 16'h0001, 16'h2234, 16'h0001};
        exp_cout = '{1'b0, 1'b1, 1'b0, 1'b1};
        run_ops(ops, 4, got, ng);
        n_cmp++;
        if (ng != 4) begin
            n_err++;
            $display("FAIL add_sub_count: got %0d results expected 4", ng);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < ng) begin
                n_cmp++;
                if (got[i].sum !== exp_sum[i] || got[i].cout !== exp_cout[i]) begin
                    n_err++;
                    $display("FAIL add_sub[%0d]: got sum=%h cout=%b expected %h %b",
                             i, got[i].sum, got[i].cout, exp_sum[i], exp_cout[i]);
                end
            end
        end
    endtask

`ifdef PIPELINED_ADDER_OVF_EN
    task automatic test_overflow();
        op_t         ops [4];
        res_t        got [4];
        int          ng;
        logic [15:0] exp_sum [3];
        logic        exp_ovf [3];
        ops[0] = {16'h7FFF, 16'h0001, 1'b0, 1'b0};
        ops[1] = {16'h8000, 16'h0001, 1'b0, 1'b1};
        ops[2] = {16'h0003, 16'h0002, 1'b0, 1'b0};
        ops[3] = '0;
        exp_sum = '{16'h8000, 16'h7FFF, 16'h0005};
        exp_ovf = '{1'b1, 1'b1, 1'b0};
        run_ops(ops, 3, got, ng);
        n_cmp++;
        if (ng != 3) begin
            n_err++;
            $display("FAIL ovf_count: got %0d results expected 3", ng);
        end
        for (int i = 0; i < 3; i++) begin
            if (i < ng) begin
                n_cmp++;
                if (got[i].sum !== exp_sum[i] || got[i].ovf !== exp_ovf[i]) begin
                    n_err++;
                    $display("FAIL ovf[%0d]: got sum=%h ovf=%b expected %h %b",
                             i, got[i].sum, got[i].ovf, exp_sum[i], exp_ovf[i]);
                end
            end
        end
    endtask
`endif

    task automatic test_backpressure();
        logic acc, deq;
        res_t obs, snap, ex;
        op_t  ops [6];
        int   idx;
        for (int i = 0; i < 6; i++) ops[i] = {16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i), 1'(i), 1'(i >> 1)};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        idx       = 0;
        for (int c = 0; c < 6; c++) begin
            {a, b, cin, sub} = ops[idx];
            cycle(acc, deq, obs);
            if (acc) idx++;
        end
        n_cmp++;
        if (idx != 4) begin
            n_err++;
            $display("FAIL bp_accepted: got %0d expected 4", idx);
        end
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_full: got in_ready=%b out_valid=%b expected 0 1", in_ready, out_valid);
        end
        snap = observe();
        for (int c = 0; c < 3; c++) begin
            {a, b, cin, sub} = ops[idx];
            cycle(acc, deq, obs);
            n_cmp++;
            if (acc !== 1'b0 || obs !== snap) begin
                n_err++;
                $display("FAIL bp_hold: got acc=%b res=%h expected 0 %h", acc, obs, snap);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle(acc, deq, obs);
            ex = (sb.size() > 0) ? sb.pop_front() : '0;
            n_cmp++;
            if (deq !== 1'b1 || obs !== ex) begin
                n_err++;
                $display("FAIL bp_drain[%0d]: got deq=%b res=%h expected 1 %h", k, deq, obs, ex);
            end
        end
        cycle(acc, deq, obs);
        n_cmp++;
        if (deq !== 1'b0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL bp_empty: got deq=%b pending=%0d expected 0 0", deq, sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic acc, deq;
        res_t obs;
        int   seen;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            {a, b, cin, sub} = {16'(16'h0100 + i), 16'h00FF, 1'b1, 1'b0};
            cycle(acc, deq, obs);
        end
        in_valid = 1'b0;
        cycle(acc, deq, obs);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midflight_loaded: got out_valid=%b expected 1", out_valid);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, observe()} !== '0) begin
            n_err++;
            $display("FAIL midflight_clear: got out_valid=%b res=%h expected all zero", out_valid, observe());
        end
        #4;
        reset_n = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midflight_ready: got %b expected 1", in_ready);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(acc, deq, obs);
            if (deq) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL midflight_stale: got %0d results expected 0", seen);
        end
    endtask

    task automatic test_random();
        logic acc, deq;
        res_t obs, ex;
        op_t  cur;
        int   sent, recv, budget;
        sent   = 0;
        recv   = 0;
        budget = 0;
        cur    = rand_op();
        while ((sent < 1000 || sb.size() > 0) && budget < 30000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            {a, b, cin, sub} = cur;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(acc, deq, obs);
            if (acc) begin
                sent++;
                cur = rand_op();
            end
            if (deq) begin
                recv++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra: got res=%h with nothing outstanding", obs);
                end else begin
                    ex = sb.pop_front();
                    if (obs !== ex) begin
                        n_err++;
                        $display("FAIL rand_result[%0d]: got %h expected %h", recv, obs, ex);
                    end
                end
            end
            budget++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (recv != 1000 || sent != 1000) begin
            n_err++;
            $display("FAIL rand_count: got sent=%0d recv=%0d expected 1000 1000", sent, recv);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_boundary_add();
        test_add_sub();
`ifdef PIPELINED_ADDER_OVF_EN
        test_overflow();
`endif
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
